// File: rtl/lcd_bus_rx.sv
// lcd_bus_rx: receiver for the 8-bit write-only LCD bus (data, WR, D/C, panel reset).
// Decodes CASET/RASET/RAMWR/SWRESET into pixel writes with linear framebuffer addresses.
// Latency: a byte produces its outputs SYNC_STAGES+1 clocks after the WR rising edge reaches the pins.
// Backpressure: none. The bus delivers at most one byte per 4 clocks, and every byte is absorbed in one cycle.
//
// Ports:
//   i_clk, i_res        system clock, asynchronous active-high reset
//   i_lcd_data/wr/dc    bus byte, write strobe (byte taken on rising edge), 0=command 1=data
//   i_lcd_rst           panel reset, active-low; behaves like i_res on decoder state
//   o_px_valid/addr/data  one-cycle pixel write, address row*WIDTH+col, RGB565 data
//   o_cmd_valid/o_cmd   one-cycle pulse per command byte, last command byte
//   o_frame_start       one-cycle pulse per RAMWR command
//   o_err               sticky protocol error
module lcd_bus_rx #(
    parameter int WIDTH       = 48,
    parameter int HEIGHT      = 640,
    parameter int ADDR_W      = 15,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_res,
    input  logic [7:0]        i_lcd_data,
    input  logic              i_lcd_wr,
    input  logic              i_lcd_dc,
    input  logic              i_lcd_rst,
    output logic              o_px_valid,
    output logic [ADDR_W-1:0] o_px_addr,
    output logic [15:0]       o_px_data,
    output logic              o_cmd_valid,
    output logic [7:0]        o_cmd,
    output logic              o_frame_start,
    output logic              o_err
);

    localparam logic [7:0]        CMD_SWRESET = 8'h01;
    localparam logic [7:0]        CMD_CASET   = 8'h2A;
    localparam logic [7:0]        CMD_RASET   = 8'h2B;
    localparam logic [7:0]        CMD_RAMWR   = 8'h2C;
    localparam logic [15:0]       XMAX        = 16'(WIDTH - 1);
    localparam logic [15:0]       YMAX        = 16'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] WIDTH_A     = ADDR_W'(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CASET,
        S_RASET,
        S_RAMWR,
        S_SKIP
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] wr_sync_q;
    logic [SYNC_STAGES-1:0] dc_sync_q;
    logic [SYNC_STAGES-1:0] rst_sync_q;
    logic [7:0]             data_sync_q [SYNC_STAGES];
    logic                   wr_prev_q;

    // WR idles high, so its chain and the edge detector reset to 1; a bus that is
    // already idle when reset is released must not look like a rising edge.
    // The panel-reset chain resets to "asserted" and releases once the pin level
    // has propagated through.
    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            wr_sync_q  <= '1;
            dc_sync_q  <= '0;
            rst_sync_q <= '0;
            wr_prev_q  <= 1'b1;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                data_sync_q[i] <= 8'h00;
            end
        end else begin
            wr_sync_q      <= {wr_sync_q[SYNC_STAGES-2:0], i_lcd_wr};
            dc_sync_q      <= {dc_sync_q[SYNC_STAGES-2:0], i_lcd_dc};
            rst_sync_q     <= {rst_sync_q[SYNC_STAGES-2:0], i_lcd_rst};
            wr_prev_q      <= wr_sync_q[SYNC_STAGES-1];
            data_sync_q[0] <= i_lcd_data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                data_sync_q[i] <= data_sync_q[i-1];
            end
        end
    end

    // Data and D/C travel through chains of the same depth as WR, so the last
    // stage of each is aligned with the detected edge.
    logic       byte_stb;
    logic [7:0] byte_dat;
    logic       byte_dc;
    logic       panel_rst;

    assign byte_stb  = wr_sync_q[SYNC_STAGES-1] & ~wr_prev_q;
    assign byte_dat  = data_sync_q[SYNC_STAGES-1];
    assign byte_dc   = dc_sync_q[SYNC_STAGES-1];
    assign panel_rst = ~rst_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Decoder state
    // ------------------------------------------------------------------
    state_t              state_q,    state_d;
    logic [1:0]          cnt_q,      cnt_d;
    logic [23:0]         par_q,      par_d;
    logic [7:0]          hi_q,       hi_d;
    logic                hi_vld_q,   hi_vld_d;
    logic [15:0]         xs_q,       xs_d;
    logic [15:0]         xe_q,       xe_d;
    logic [15:0]         ys_q,       ys_d;
    logic [15:0]         ye_q,       ye_d;
    logic [15:0]         col_q,      col_d;
    logic [15:0]         row_q,      row_d;
    logic                px_vld_q,   px_vld_d;
    logic [ADDR_W-1:0]   px_addr_q,  px_addr_d;
    logic [15:0]         px_dat_q,   px_dat_d;
    logic                cmd_vld_q,  cmd_vld_d;
    logic [7:0]          cmd_q,      cmd_d;
    logic                frame_q,    frame_d;
    logic                err_q,      err_d;

    // Window-commit scratch values
    logic [15:0]         prm_start;
    logic [15:0]         prm_stop;
    logic [15:0]         prm_lim;

    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            state_q   <= S_IDLE;
            cnt_q     <= 2'd0;
            par_q     <= 24'h0;
            hi_q      <= 8'h00;
            hi_vld_q  <= 1'b0;
            xs_q      <= 16'd0;
            xe_q      <= XMAX;
            ys_q      <= 16'd0;
            ye_q      <= YMAX;
            col_q     <= 16'd0;
            row_q     <= 16'd0;
            px_vld_q  <= 1'b0;
            px_addr_q <= '0;
            px_dat_q  <= 16'h0;
            cmd_vld_q <= 1'b0;
            cmd_q     <= 8'h00;
            frame_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            par_q     <= par_d;
            hi_q      <= hi_d;
            hi_vld_q  <= hi_vld_d;
            xs_q      <= xs_d;
            xe_q      <= xe_d;
            ys_q      <= ys_d;
            ye_q      <= ye_d;
            col_q     <= col_d;
            row_q     <= row_d;
            px_vld_q  <= px_vld_d;
            px_addr_q <= px_addr_d;
            px_dat_q  <= px_dat_d;
            cmd_vld_q <= cmd_vld_d;
            cmd_q     <= cmd_d;
            frame_q   <= frame_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        par_d     = par_q;
        hi_d      = hi_q;
        hi_vld_d  = hi_vld_q;
        xs_d      = xs_q;
        xe_d      = xe_q;
        ys_d      = ys_q;
        ye_d      = ye_q;
        col_d     = col_q;
        row_d     = row_q;
        px_vld_d  = 1'b0;
        px_addr_d = px_addr_q;
        px_dat_d  = px_dat_q;
        cmd_vld_d = 1'b0;
        cmd_d     = cmd_q;
        frame_d   = 1'b0;
        err_d     = err_q;
        prm_start = par_q[23:8];
        prm_stop  = {par_q[7:0], byte_dat};
        prm_lim   = (state_q == S_CASET) ? XMAX : YMAX;

        if (panel_rst) begin
            // Panel reset holds everything at its power-on value; bytes seen
            // meanwhile are dropped.
            state_d   = S_IDLE;
            cnt_d     = 2'd0;
            par_d     = 24'h0;
            hi_d      = 8'h00;
            hi_vld_d  = 1'b0;
            xs_d      = 16'd0;
            xe_d      = XMAX;
            ys_d      = 16'd0;
            ye_d      = YMAX;
            col_d     = 16'd0;
            row_d     = 16'd0;
            px_addr_d = '0;
            px_dat_d  = 16'h0;
            cmd_d     = 8'h00;
            err_d     = 1'b0;
        end else if (byte_stb && !byte_dc) begin
            // Any command abandons a half pixel or partial parameter set.
            cmd_vld_d = 1'b1;
            cmd_d     = byte_dat;
            hi_vld_d  = 1'b0;
            cnt_d     = 2'd0;
            case (byte_dat)
                CMD_CASET: state_d = S_CASET;
                CMD_RASET: state_d = S_RASET;
                CMD_RAMWR: begin
                    state_d = S_RAMWR;
                    col_d   = xs_q;
                    row_d   = ys_q;
                    frame_d = 1'b1;
                end
                CMD_SWRESET: begin
                    state_d = S_IDLE;
                    xs_d    = 16'd0;
                    xe_d    = XMAX;
                    ys_d    = 16'd0;
                    ye_d    = YMAX;
                    col_d   = 16'd0;
                    row_d   = 16'd0;
                    err_d   = 1'b0;
                end
                default: state_d = S_SKIP;
            endcase
        end else if (byte_stb) begin
            case (state_q)
                S_IDLE: err_d = 1'b1;
                S_CASET, S_RASET: begin
                    if (cnt_q != 2'd3) begin
                        par_d = {par_q[15:0], byte_dat};
                        cnt_d = cnt_q + 2'd1;
                    end else begin
                        // Fourth byte: clamp the end, then commit both edges
                        // together or neither.
                        if (prm_stop > prm_lim) begin
                            err_d    = 1'b1;
                            prm_stop = prm_lim;
                        end
                        if (prm_start > prm_stop) begin
                            err_d = 1'b1;
                        end else if (state_q == S_CASET) begin
                            xs_d = prm_start;
                            xe_d = prm_stop;
                        end else begin
                            ys_d = prm_start;
                            ye_d = prm_stop;
                        end
                        cnt_d   = 2'd0;
                        state_d = S_SKIP;
                    end
                end
                S_RAMWR: begin
                    if (!hi_vld_q) begin
                        hi_d     = byte_dat;
                        hi_vld_d = 1'b1;
                    end else begin
                        hi_vld_d  = 1'b0;
                        px_vld_d  = 1'b1;
                        px_dat_d  = {hi_q, byte_dat};
                        px_addr_d = ADDR_W'(row_q) * WIDTH_A + ADDR_W'(col_q);
                        // ">=" rather than "==" so a window shrunk mid-frame
                        // still wraps instead of running the pointer off.
                        if (col_q >= xe_q) begin
                            col_d = xs_q;
                            if (row_q >= ye_q) begin
                                row_d = ys_q;
                            end else begin
                                row_d = row_q + 16'd1;
                            end
                        end else begin
                            col_d = col_q + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_px_valid    = px_vld_q;
    assign o_px_addr     = px_addr_q;
    assign o_px_data     = px_dat_q;
    assign o_cmd_valid   = cmd_vld_q;
    assign o_cmd         = cmd_q;
    assign o_frame_start = frame_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_lcd_bus_rx.sv
// tb_lcd_bus_rx: self-checking bench for lcd_bus_rx.
// A byte table drives the bus; pixel expectations go to a scoreboard popped on o_px_valid.
// Hand-written sequences cover i_res mid-pixel and panel reset mid-stream.
module tb_lcd_bus_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  lcd_data;
    logic        lcd_wr;
    logic        lcd_dc;
    logic        lcd_rst;
    logic        px_valid;
    logic [14:0] px_addr;
    logic [15:0] px_data;
    logic        cmd_valid;
    logic [7:0]  cmd;
    logic        frame_start;
    logic        err;

    always #5 clk = ~clk;

    lcd_bus_rx #(
        .WIDTH(48), .HEIGHT(640), .ADDR_W(15), .SYNC_STAGES(2)
    ) dut (
        .i_clk         (clk),
        .i_res         (rst),
        .i_lcd_data    (lcd_data),
        .i_lcd_wr      (lcd_wr),
        .i_lcd_dc      (lcd_dc),
        .i_lcd_rst     (lcd_rst),
        .o_px_valid    (px_valid),
        .o_px_addr     (px_addr),
        .o_px_data     (px_data),
        .o_cmd_valid   (cmd_valid),
        .o_cmd         (cmd),
        .o_frame_start (frame_start),
        .o_err         (err)
    );

    typedef struct {
        logic        dc;
        logic [7:0]  b;
        logic        px;
        logic [14:0] addr;
        logic [15:0] data;
        logic        err;
    } vec_t;

    typedef struct {
        logic [14:0] addr;
        logic [15:0] data;
    } pix_t;

    vec_t vecs[$];
    pix_t sb[$];
    int   n_vec     = 0;
    int   n_bad     = 0;
    int   cmd_cnt   = 0;
    int   frame_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic dc, input logic [7:0] b, input logic px,
                       input int addr, input logic [15:0] data, input logic e);
        vec_t v;
        v.dc = dc; v.b = b; v.px = px; v.addr = 15'(addr); v.data = data; v.err = e;
        vecs.push_back(v);
    endtask

    task automatic c(input logic [7:0] b, input logic e);
        add(1'b0, b, 1'b0, 0, 16'h0, e);
    endtask

    task automatic p(input logic [7:0] b, input logic e);
        add(1'b1, b, 1'b0, 0, 16'h0, e);
    endtask

    task automatic pix(input logic [7:0] hi, input logic [7:0] lo, input int addr, input logic e);
        add(1'b1, hi, 1'b0, 0, 16'h0, e);
        add(1'b1, lo, 1'b1, addr, {hi, lo}, e);
    endtask

    task automatic expect_px(input int addr, input logic [15:0] data);
        pix_t q;
        q.addr = 15'(addr);
        q.data = data;
        sb.push_back(q);
    endtask

    // One bus write: WR low 3 clk, high 4 clk, data held throughout.
    task automatic send_byte(input logic dc, input logic [7:0] b);
        @(negedge clk);
        lcd_dc   = dc;
        lcd_data = b;
        lcd_wr   = 1'b0;
        repeat (3) @(negedge clk);
        lcd_wr = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Pixel scoreboard and pulse counters
    always @(negedge clk) begin
        pix_t e;
        if (px_valid) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL px_unexpected: got addr %0d data %h, expected no pixel", px_addr, px_data);
            end else begin
                e = sb.pop_front();
                if (px_addr !== e.addr || px_data !== e.data) begin
                    n_bad++;
                    $display("FAIL px: got addr %0d data %h, expected addr %0d data %h",
                             px_addr, px_data, e.addr, e.data);
                end
            end
        end
        if (cmd_valid)   cmd_cnt++;
        if (frame_start) frame_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int c0, f0, ncmd, nramwr;

        rst = 1'b1; lcd_rst = 1'b1; lcd_wr = 1'b1; lcd_dc = 1'b0; lcd_data = 8'h00;

        // Full window
        c(8'h2A, 0); p(8'h00, 0); p(8'h00, 0); p(8'h00, 0); p(8'h2F, 0);
        c(8'h2B, 0); p(8'h00, 0); p(8'h00, 0); p(8'h02, 0); p(8'h7F, 0);
        c(8'h2C, 0); pix(8'hF8, 8'h00, 0, 0); pix(8'h07, 8'hE0, 1, 0);
        // Window wrap: cols 10..11, rows 5..6
        c(8'h2A, 0); p(8'h00, 0); p(8'h0A, 0); p(8'h00, 0); p(8'h0B, 0);
        c(8'h2B, 0); p(8'h00, 0); p(8'h05, 0); p(8'h00, 0); p(8'h06, 0);
        c(8'h2C, 0);
        pix(8'h00, 8'h01, 250, 0); pix(8'h00, 8'h02, 251, 0); pix(8'h00, 8'h03, 298, 0);
        pix(8'h00, 8'h04, 299, 0); pix(8'h00, 8'h05, 250, 0);
        // Odd byte dropped by a command
        c(8'h2C, 0); p(8'hAA, 0); c(8'h2C, 0); pix(8'h12, 8'h34, 250, 0);
        // start > end: error, window unchanged
        c(8'h2A, 0); p(8'h00, 0); p(8'h28, 0); p(8'h00, 0); p(8'h14, 1);
        c(8'h2C, 1); pix(8'hAB, 8'hCD, 250, 1);
        // end 99 clamped to 47: cols 46..47
        c(8'h2A, 1); p(8'h00, 1); p(8'h2E, 1); p(8'h00, 1); p(8'h63, 1);
        c(8'h2C, 1); pix(8'h01, 8'h02, 286, 1); pix(8'h03, 8'h04, 287, 1); pix(8'h05, 8'h06, 334, 1);
        // SWRESET clears error and window; data in IDLE flags an error
        c(8'h01, 0); p(8'h55, 1); c(8'h2C, 1); pix(8'h11, 8'h22, 0, 1);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_px_valid", px_valid, 0);
        chk("rst_px_addr", px_addr, 0);
        chk("rst_px_data", px_data, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd", cmd, 0);
        chk("rst_frame", frame_start, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // i_res in the middle of a byte pair
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'hF8);
        #2 rst = 1'b1;
        #1;
        chk("midrst_cmd", cmd, 0);
        chk("midrst_px_valid", px_valid, 0);
        chk("midrst_err", err, 0);
        @(negedge clk) rst = 1'b0;
        repeat (5) @(negedge clk);
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'hF8);
        expect_px(0, 16'hF800);
        send_byte(1'b1, 8'h00);
        chk("midrst_err_after", err, 0);

        // Table
        c0 = cmd_cnt; f0 = frame_cnt; ncmd = 0; nramwr = 0;
        foreach (vecs[i]) begin
            if (vecs[i].px) expect_px(int'(vecs[i].addr), vecs[i].data);
            if (!vecs[i].dc) begin
                ncmd++;
                if (vecs[i].b == 8'h2C) nramwr++;
            end
            send_byte(vecs[i].dc, vecs[i].b);
            chk($sformatf("err[%0d]", i), err, vecs[i].err);
            if (!vecs[i].dc) chk($sformatf("cmd[%0d]", i), cmd, vecs[i].b);
        end
        chk("cmd_pulses", cmd_cnt - c0, ncmd);
        chk("frame_pulses", frame_cnt - f0, nramwr);
        chk("sb_drain_table", sb.size(), 0);

        // Panel reset mid-stream
        send_byte(1'b0, 8'h2A);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h05);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h06);
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'hAA);
        chk("prst_err_before", err, 1);
        c0 = cmd_cnt; f0 = frame_cnt;
        @(negedge clk) lcd_rst = 1'b0;
        @(negedge clk);
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'h12);
        chk("prst_err_cleared", err, 0);
        chk("prst_no_cmd", cmd_cnt, c0);
        chk("prst_no_frame", frame_cnt, f0);
        lcd_rst = 1'b1;
        repeat (5) @(negedge clk);
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'h56);
        expect_px(0, 16'h5678);
        send_byte(1'b1, 8'h78);
        chk("prst_frame_after", frame_cnt, f0 + 1);
        chk("prst_err_after", err, 0);
        repeat (4) @(negedge clk);
        chk("sb_drain_final", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
